// File: rtl/dmem_port_arbiter_if.sv
// Bundle between the MEM stage, the DMA requester, the arbiter and the SRAM.
// master = arbiter side, slave = requesters plus memory.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 14
);
    logic              cpu_req;
    logic [3:0]        cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;

    logic              dma_req;
    logic [3:0]        dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [31:0]       dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [31:0]       dma_rdata;

    logic              mem_cs;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_cs, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_cs, mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory SRAM port between the CPU MEM stage and DMA.
// Define DMEM_ARB_STARVE_EN to add the DMA starvation counter / forced grant.
module dmem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 8
) (
    input logic clk,
    input logic rst,
    dmem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_CPU,
        RSP_DMA
    } rsp_t;

    rsp_t              state;
    logic              cpu_gnt;
    logic              dma_gnt;
    logic              force_dma;
    logic [31:0]       cpu_hold;
    logic [31:0]       dma_hold;
    logic [3:0]        we_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [31:0]       din_mux;

    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
        $error("dmem_port_arbiter: STARVE_MAX must be 1..255");
    end

`ifdef DMEM_ARB_STARVE_EN
    logic [7:0] starve_cnt;

    assign force_dma = (starve_cnt == 8'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.dma_req || dma_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != 8'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    assign force_dma = 1'b0;
`endif

    // CPU wins ties unless DMA has waited STARVE_MAX cycles.
    assign dma_gnt = bus.dma_req & (~bus.cpu_req | force_dma);
    assign cpu_gnt = bus.cpu_req & ~dma_gnt;

    always_comb begin
        we_mux   = '0;
        addr_mux = '0;
        din_mux  = '0;
        unique case (1'b1)
            cpu_gnt: begin
                we_mux   = bus.cpu_we;
                addr_mux = bus.cpu_addr;
                din_mux  = bus.cpu_wdata;
            end
            dma_gnt: begin
                we_mux   = bus.dma_we;
                addr_mux = bus.dma_addr;
                din_mux  = bus.dma_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RSP_NONE;
            cpu_hold <= '0;
            dma_hold <= '0;
        end else begin
            if (state == RSP_CPU) cpu_hold <= bus.mem_dout;
            if (state == RSP_DMA) dma_hold <= bus.mem_dout;
            unique case (1'b1)
                cpu_gnt && bus.cpu_we == 4'b0000: state <= RSP_CPU;
                dma_gnt && bus.dma_we == 4'b0000: state <= RSP_DMA;
                default:                          state <= RSP_NONE;
            endcase
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dma_gnt    = dma_gnt;
    assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
    assign bus.mem_cs     = cpu_gnt | dma_gnt;
    assign bus.mem_we     = we_mux;
    assign bus.mem_addr   = addr_mux;
    assign bus.mem_din    = din_mux;
    assign bus.cpu_rvalid = (state == RSP_CPU);
    assign bus.dma_rvalid = (state == RSP_DMA);
    assign bus.cpu_rdata  = (state == RSP_CPU) ? bus.mem_dout : cpu_hold;
    assign bus.dma_rdata  = (state == RSP_DMA) ? bus.mem_dout : dma_hold;
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single data-memory SRAM port between the CPU MEM stage and a secondary DMA requester. Each cycle it picks one single-beat access, drives the SRAM chip-select, byte-lane write-enable, address and write data, and routes the one-cycle-late read data back to the requester that issued the read. It sits between the MEM stage and the data memory, and produces the CPU stall when the CPU loses arbitration.

## Interface
- ADDR_W, 14, word-address width to the SRAM
- STARVE_MAX, 8, DMA wait cycles tolerated before DMA is forced a grant; legal range 1..255
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  4  byte-lane write enables; 4'b0000 means read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  32  CPU write data, already lane-aligned
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  32  CPU read data
- dma_req, dma_we, dma_addr, dma_wdata  in  1/4/ADDR_W/32  DMA request, same meaning as the CPU signals
- dma_gnt, dma_rvalid  out  1  same meaning as the CPU signals
- dma_rdata  out  32  DMA read data
- mem_cs  out  1  SRAM chip select
- mem_we  out  4  SRAM byte write enables
- mem_addr  out  ADDR_W  SRAM address
- mem_din  out  32  SRAM write data
- mem_dout  in  32  SRAM read data; valid the cycle after the read is issued

## Operation
- Grant decision is combinational from the requests and the registered arbiter state. At most one of cpu_gnt and dma_gnt is high in any cycle.
- Default policy is fixed priority, CPU first:
  - cpu_req alone → CPU.
  - dma_req alone → DMA.
  - Both requesting → CPU, unless the starvation rule forces DMA.
- SRAM drive:
  - mem_cs = cpu_gnt | dma_gnt.
  - mem_we, mem_addr and mem_din are muxed from the granted requester.
  - All SRAM outputs are 0 when nothing is granted.
- Response tracking FSM, registered, states RSP_NONE, RSP_CPU, RSP_DMA:
  - Next state is RSP_CPU if this cycle grants a CPU read (cpu_we==0).
  - Next state is RSP_DMA if this cycle grants a DMA read.
  - Otherwise next state is RSP_NONE. Writes never produce a response.
- Response outputs:
  - cpu_rvalid = (state==RSP_CPU); dma_rvalid = (state==RSP_DMA).
  - While a requester's rvalid is high, its rdata = mem_dout.
  - Otherwise its rdata holds the last value delivered to that requester, from a per-requester hold register captured when rvalid is high. Both hold registers are 0 after reset.
- Starvation counter starve_cnt, 8 bits:
  - Increments in each cycle with dma_req & ~dma_gnt, saturating at STARVE_MAX.
  - Clears on any dma_gnt or when dma_req is low.
  - When starve_cnt==STARVE_MAX, DMA wins over a simultaneous cpu_req.
- No address alignment, sign extension or lane shifting is done here; requesters present lane-aligned data.

## Timing
- Grant latency 0: an unopposed request is granted in the same cycle.
- Read latency 1: a grant in cycle N gives rvalid in cycle N+1.
- Throughput: one access per cycle. Back-to-back reads from different requesters are legal; the FSM routes each response correctly.
- Reset values: all outputs 0, state RSP_NONE, starve_cnt 0. A read granted in the cycle rst is asserted produces no rvalid.
- Requests are sampled combinationally. A requester must hold its req, we, addr and wdata stable until it sees gnt.

## Configuration
- DMEM_ARB_STARVE_EN defined: the starvation counter and forced DMA grant are present as described above.
- DMEM_ARB_STARVE_EN undefined:
  - The counter is removed.
  - The CPU always wins simultaneous requests.
  - STARVE_MAX is ignored.
  - DMA can starve indefinitely while cpu_req is held high.

## Test plan
- After reset, a single CPU read to addr 0x010 with mem_dout=0xDEADBEEF → cpu_gnt in cycle 0, mem_cs=1, mem_we=0; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF in cycle 1; dma_rvalid stays 0.
- CPU write, we=4'b0011, addr 0x004, wdata 0x0000ABCD → mem_we=4'b0011, mem_din=0x0000ABCD in the grant cycle; no rvalid in the following cycle.
- CPU and DMA both request continuously with the macro defined and STARVE_MAX=8 → CPU is granted for 8 cycles, then DMA in cycle 8 with cpu_stall=1; the counter clears and the pattern repeats.
- Same stimulus with the macro undefined → dma_gnt stays 0 for 50 cycles.
- DMA read in cycle N and CPU read in cycle N+1, with mem_dout=0x11 then 0x22 → dma_rvalid with 0x11 in N+1, cpu_rvalid with 0x22 in N+2; each rdata then holds its value.
- rst asserted in the same cycle as a granted CPU read → cpu_rvalid=0 in the next cycle; all outputs read 0.
